noc_rr_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one valid/ready NoC output link between NUM_SRC source ports.
- Sits upstream of the NoC transfer controller; its output link drives that controller's src_valid/src_ready side.
- Grants are per packet: one source owns the link from grant until its last beat completes or a watchdog expires.

---
 rtl/noc_arb_pkg.sv | 13 +
 rtl/rr_priority_picker.sv | 28 ++
 rtl/noc_rr_arbiter.sv | 116 +++++++++++
 tb/tb_noc_rr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the packet-level NoC round-robin arbiter.
package noc_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_priority_picker
  import noc_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    cand  = int'(ptr);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && req[ID_W'(cand)]) begin
        found = 1'b1;
        idx   = ID_W'(cand);
      end
      cand = rr_next(cand, NUM_SRC);
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one valid/ready link between NUM_SRC sources,
// with a per-packet beat watchdog that force-releases runaway grants.
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter  int NUM_SRC   = 4,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BEATS = 64,
  localparam int ID_W      = $clog2(NUM_SRC)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_last,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy,
  output logic                        wdog_err
);

  localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam bit WDOG_EN = (MAX_BEATS > 0);
  // Watchdog fires on the beat that would complete MAX_BEATS, i.e. when MAX_BEATS-1 are already counted.
  localparam logic [CNT_W-1:0] WDOG_LAST = (MAX_BEATS > 0) ? CNT_W'(MAX_BEATS - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  arb_state_t       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;

  logic              owner_valid;
  logic              owner_last;
  logic [DATA_W-1:0] owner_data;
  logic              beat;
  logic              wdog_hit;
  logic [ID_W-1:0]   next_ptr;

  rr_priority_picker #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_picker (
    .req   (src_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_valid = src_valid[grant_id];
  assign owner_last  = src_last[grant_id];
  assign owner_data  = src_data[grant_id*DATA_W +: DATA_W];
  assign beat        = (state == OWN) && owner_valid && out_ready;
  assign wdog_hit    = WDOG_EN && (beat_cnt == WDOG_LAST);
  assign next_ptr    = ID_W'(rr_next(int'(grant_id), NUM_SRC));

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    src_ready = '0;
    busy      = 1'b0;
    if (state == OWN) begin
      busy                = 1'b1;
      out_valid           = owner_valid;
      out_data            = owner_data;
      out_last            = owner_last;
      src_ready[grant_id] = out_ready;
    end
  end

  // Release always lands in IDLE, which guarantees one idle cycle between packets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= OWN;
            grant_id <= pick_idx;
            beat_cnt <= '0;
          end
        end
        OWN: begin
          if (beat) begin
            if (beat_cnt != CNT_MAX) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            if (owner_last) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end else if (wdog_hit) begin
              state    <= IDLE;
              rr_ptr   <= next_ptr;
              wdog_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_noc_rr_arbiter;

  localparam int NUM_SRC   = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 4;
  localparam int ID_W      = 2;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_SRC-1:0]        src_valid = '0;
  logic [NUM_SRC*DATA_W-1:0] src_data = '0;
  logic [NUM_SRC-1:0]        src_last = '0;
  logic                      out_ready = 1'b0;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic                      wdog_err;

  always #5 clk = ~clk;

  noc_rr_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_last  (src_last),
    .src_ready (src_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .wdog_err  (wdog_err)
  );

  int total = 0;
  int bad   = 0;

  // Model state: owner index (-1 when nobody owns the link), round-robin pointer, beats taken.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  bit m_wd    = 1'b0;
  logic [NUM_SRC-1:0] fire_vec = '0;

  bit req_en[NUM_SRC];
  bit hold[NUM_SRC];
  int plen[NUM_SRC];
  int beat_idx[NUM_SRC];
  int pkt[NUM_SRC];
  bit rdy_knob = 1'b0;

  logic               exp_valid;
  logic               exp_last;
  logic               exp_busy;
  logic [DATA_W-1:0]  exp_data;
  logic [NUM_SRC-1:0] exp_ready;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] flit_word(input int i, input int p, input int b);
    return {8'(i), 8'(p), 8'(b), 8'h5A};
  endfunction

  // Every falling edge: compare against the model, then advance it to the next rising edge.
  always @(negedge clk) begin
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    exp_busy  = 1'b0;
    exp_data  = '0;
    exp_ready = '0;
    if (!reset && m_owner >= 0) begin
      exp_busy  = 1'b1;
      exp_valid = src_valid[m_owner];
      exp_last  = src_last[m_owner];
      exp_data  = src_data[m_owner*DATA_W +: DATA_W];
      exp_ready = out_ready ? NUM_SRC'(1 << m_owner) : '0;
    end
    check_output("out_valid", 32'(out_valid), 32'(exp_valid));
    check_output("out_last", 32'(out_last), 32'(exp_last));
    check_output("out_data", out_data, exp_data);
    check_output("busy", 32'(busy), 32'(exp_busy));
    check_output("src_ready", 32'(src_ready), 32'(exp_ready));
    check_output("wdog_err", 32'(wdog_err), reset ? 32'd0 : 32'(m_wd));
    check_output("src_ready_onehot0", 32'($onehot0(src_ready)), 32'd1);
    if (reset) check_output("grant_id_reset", 32'(grant_id), 32'd0);
    else if (m_owner >= 0) check_output("grant_id", 32'(grant_id), 32'(m_owner));
    fire_vec = reset ? '0 : (src_valid & exp_ready);

    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_wd    = 1'b0;
    end else begin
      m_wd = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < NUM_SRC; k++) begin
          if (m_owner < 0 && src_valid[(m_ptr + k) % NUM_SRC]) begin
            m_owner = (m_ptr + k) % NUM_SRC;
            m_beats = 0;
          end
        end
      end else if (src_valid[m_owner] && out_ready) begin
        m_beats++;
        if (src_last[m_owner]) begin
          m_ptr   = (m_owner + 1) % NUM_SRC;
          m_owner = -1;
        end else if (MAX_BEATS > 0 && m_beats == MAX_BEATS) begin
          m_ptr   = (m_owner + 1) % NUM_SRC;
          m_owner = -1;
          m_wd    = 1'b1;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_valid[i] = req_en[i] && !hold[i];
      src_last[i]  = (beat_idx[i] == plen[i] - 1);
      src_data[i*DATA_W +: DATA_W] = flit_word(i, pkt[i], beat_idx[i]);
    end
    out_ready = rdy_knob;
  endtask

  // One clock: advance each source past any beat it delivered, then drive the next inputs.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (fire_vec[i]) begin
        if (beat_idx[i] == plen[i] - 1) begin
          beat_idx[i] = 0;
          pkt[i]++;
        end else begin
          beat_idx[i]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      req_en[i]   = 1'b0;
      hold[i]     = 1'b0;
      beat_idx[i] = 0;
    end
    drive();
    #1;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_src_ready", 32'(src_ready), 32'd0);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive();
    #1;
  endtask

  initial begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req_en[i] = 1'b0; hold[i] = 1'b0; plen[i] = 1; beat_idx[i] = 0; pkt[i] = 0;
    end
    drive();

    // Sources 0 and 2 with 2-beat packets.
    do_reset();
    rdy_knob = 1'b1;
    req_en[0] = 1'b1; req_en[2] = 1'b1; plen[0] = 2; plen[2] = 2;
    apply_stimulus();
    check_output("t1_idle_before_grant", 32'(busy), 32'd0);
    apply_stimulus();
    check_output("t1_grant0", 32'(grant_id), 32'd0);
    check_output("t1_latency_valid", 32'(out_valid), 32'd1);
    check_output("t1_ready0", 32'(src_ready), 32'b0001);
    apply_stimulus();
    check_output("t1_last_beat", 32'(out_last), 32'd1);
    apply_stimulus();
    check_output("t1_gap", 32'(busy), 32'd0);
    apply_stimulus();
    check_output("t1_grant2", 32'(grant_id), 32'd2);
    apply_stimulus();
    apply_stimulus();
    check_output("t1_gap2", 32'(busy), 32'd0);
    apply_stimulus();
    check_output("t1_regrant0", 32'(grant_id), 32'd0);

    // All sources, 1-beat packets: strict rotation with wrap.
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) begin
      req_en[i] = 1'b1; plen[i] = 1;
    end
    apply_stimulus();
    for (int k = 0; k < 5; k++) begin
      apply_stimulus();
      check_output("t2_grant_order", 32'(grant_id), 32'(k % NUM_SRC));
      check_output("t2_busy", 32'(busy), 32'd1);
      apply_stimulus();
      check_output("t2_gap", 32'(busy), 32'd0);
    end

    // Owner 1 drops valid mid-packet while source 2 waits.
    do_reset();
    req_en[1] = 1'b1; plen[1] = 3; plen[2] = 2;
    apply_stimulus();
    apply_stimulus();
    check_output("t3_grant1", 32'(grant_id), 32'd1);
    hold[1] = 1'b1; req_en[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus();
      check_output("t3_hold_valid", 32'(out_valid), 32'd0);
      check_output("t3_hold_grant", 32'(grant_id), 32'd1);
      check_output("t3_hold_ready", 32'(src_ready), 32'b0010);
    end
    hold[1] = 1'b0;
    apply_stimulus();
    check_output("t3_resume_valid", 32'(out_valid), 32'd1);
    apply_stimulus();
    apply_stimulus();
    check_output("t3_release", 32'(busy), 32'd0);
    apply_stimulus();
    check_output("t3_grant2", 32'(grant_id), 32'd2);

    // Downstream stall during beat 2 of 4.
    do_reset();
    req_en[0] = 1'b1; plen[0] = 4;
    apply_stimulus();
    apply_stimulus();
    rdy_knob = 1'b0;
    apply_stimulus();
    for (int k = 0; k < 5; k++) begin
      check_output("t4_stall_data", out_data, flit_word(0, pkt[0], 1));
      check_output("t4_stall_ready", 32'(src_ready), 32'd0);
      check_output("t4_stall_busy", 32'(busy), 32'd1);
      if (k < 4) apply_stimulus();
    end
    rdy_knob = 1'b1;
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("t4_final_last", 32'(out_last), 32'd1);
    apply_stimulus();
    check_output("t4_done", 32'(busy), 32'd0);

    // Watchdog: source 3 never sends last.
    do_reset();
    req_en[3] = 1'b1; plen[3] = 100; plen[2] = 1;
    apply_stimulus();
    apply_stimulus();
    check_output("t5_grant3", 32'(grant_id), 32'd3);
    req_en[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus();
      check_output("t5_busy", 32'(busy), 32'd1);
      check_output("t5_no_wdog", 32'(wdog_err), 32'd0);
    end
    apply_stimulus();
    check_output("t5_wdog_release", 32'(busy), 32'd0);
    check_output("t5_wdog_pulse", 32'(wdog_err), 32'd1);
    apply_stimulus();
    check_output("t5_wdog_single", 32'(wdog_err), 32'd0);
    check_output("t5_ptr_wrap", 32'(grant_id), 32'd2);

    // Reset in the middle of a packet.
    do_reset();
    req_en[1] = 1'b1; plen[1] = 4;
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    apply_stimulus();
    check_output("t6_mid_packet", 32'(busy), 32'd1);
    do_reset();
    req_en[2] = 1'b1; req_en[3] = 1'b1;
    apply_stimulus();
    apply_stimulus();
    check_output("t6_grant2", 32'(grant_id), 32'd2);

    // Randomized traffic.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if ($urandom_range(0, 9) == 0) req_en[i] = !req_en[i];
        if (beat_idx[i] == 0 && $urandom_range(0, 3) == 0) plen[i] = int'($urandom_range(1, 6));
      end
      rdy_knob = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else apply_stimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
